// File: rtl/wb_register_file.sv
// wb_register_file
//   Write-back stage of the pipeline: picks the write-back value from the MEM/WB
//   register, commits it to a 2**ADDR_W x DATA_W register file and serves the two
//   ID-stage read ports. When BYPASS is set, a read that hits the register being
//   written this cycle sees the new value in the same cycle. A retire counter
//   counts every committed write.
//
// Ports
//   clk              in   1        rising-edge clock
//   reset            in   1        asynchronous, active-low reset
//   wb_reg_write_i   in   1        RegWrite from MEM/WB
//   wb_mem_to_reg_i  in   1        MemtoReg: 1 = ReadData, 0 = ALUResult
//   wb_read_data_i   in   DATA_W   load data from MEM/WB
//   wb_alu_result_i  in   DATA_W   ALU result from MEM/WB
//   wb_write_reg_i   in   ADDR_W   destination register from MEM/WB
//   rs_addr_i        in   ADDR_W   read port A address
//   rt_addr_i        in   ADDR_W   read port B address
//   rs_data_o        out  DATA_W   read port A data (combinational)
//   rt_data_o        out  DATA_W   read port B data (combinational)
//   wb_data_o        out  DATA_W   selected write-back value (to forwarding unit)
//   retire_count_o   out  COUNT_W  number of committed register writes (wraps)

module wb_register_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int BYPASS  = 1,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_reg_write_i,
    input  logic               wb_mem_to_reg_i,
    input  logic [DATA_W-1:0]  wb_read_data_i,
    input  logic [DATA_W-1:0]  wb_alu_result_i,
    input  logic [ADDR_W-1:0]  wb_write_reg_i,
    input  logic [ADDR_W-1:0]  rs_addr_i,
    input  logic [ADDR_W-1:0]  rt_addr_i,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic [COUNT_W-1:0] retire_count_o
);

    localparam int NUM_REGS  = 2 ** ADDR_W;
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en;

    assign wb_data_o = wb_mem_to_reg_i ? wb_read_data_i : wb_alu_result_i;

    // RegWrite gates the address compare, so an undriven destination while
    // RegWrite is low cannot enable a write. Register 0 is never a target.
    assign wr_en = wb_reg_write_i && (wb_write_reg_i != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            retire_count_o <= '0;
        end else if (wr_en) begin
            regs[wb_write_reg_i] <= wb_data_o;
            retire_count_o       <= retire_count_o + COUNT_W'(1);
        end
    end

    // Read ports: held at zero during reset, register 0 always reads zero
    // (bypass included), then bypass hit, then array contents.
    always_comb begin
        rs_data_o = '0;
        if (reset && (rs_addr_i != '0)) begin
            if (BYPASS_EN && wr_en && (rs_addr_i == wb_write_reg_i)) begin
                rs_data_o = wb_data_o;
            end else begin
                rs_data_o = regs[rs_addr_i];
            end
        end
    end

    always_comb begin
        rt_data_o = '0;
        if (reset && (rt_addr_i != '0)) begin
            if (BYPASS_EN && wr_en && (rt_addr_i == wb_write_reg_i)) begin
                rt_data_o = wb_data_o;
            end else begin
                rt_data_o = regs[rt_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;

    logic [31:0] rs_a, rt_a, wb_a;
    logic [3:0]  cnt_a;
    logic [31:0] rs_b, rt_b, wb_b;
    logic [3:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    // Bypassing instance
    wb_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .COUNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_reg_write_i  (reg_write),
        .wb_mem_to_reg_i (mem_to_reg),
        .wb_read_data_i  (read_data),
        .wb_alu_result_i (alu_result),
        .wb_write_reg_i  (write_reg),
        .rs_addr_i       (rs_addr),
        .rt_addr_i       (rt_addr),
        .rs_data_o       (rs_a),
        .rt_data_o       (rt_a),
        .wb_data_o       (wb_a),
        .retire_count_o  (cnt_a)
    );

    // Non-bypassing instance sharing the same stimulus
    wb_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .COUNT_W(4)) dut_nb (
        .clk             (clk),
        .reset           (reset),
        .wb_reg_write_i  (reg_write),
        .wb_mem_to_reg_i (mem_to_reg),
        .wb_read_data_i  (read_data),
        .wb_alu_result_i (alu_result),
        .wb_write_reg_i  (write_reg),
        .rs_addr_i       (rs_addr),
        .rt_addr_i       (rt_addr),
        .rs_data_o       (rs_b),
        .rt_data_o       (rt_b),
        .wb_data_o       (wb_b),
        .retire_count_o  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr);
        reg_write  = we;
        mem_to_reg = m2r;
        read_data  = rd;
        alu_result = alu;
        write_reg  = wr;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rs_a !== 32'h0) begin failures++; $display("FAIL reset_rs_a got=%h exp=%h", rs_a, 32'h0); end
        checks++;
        if (rt_b !== 32'h0) begin failures++; $display("FAIL reset_rt_b got=%h exp=%h", rt_b, 32'h0); end
        checks++;
        if (cnt_a !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        checks++;
        if (wb_a !== 32'h0000_1234) begin failures++; $display("FAIL reset_wb_data got=%h exp=%h", wb_a, 32'h0000_1234); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        reset = 1'b1;
        #1;
        checks++;
        if (rs_a !== 32'h0) begin failures++; $display("FAIL release_rs5 got=%h exp=%h", rs_a, 32'h0); end
        checks++;
        if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failures++; $display("FAIL release_cnt got=%0d/%0d exp=0", cnt_a, cnt_b); end
    endtask

    task automatic test_alu_write;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0011, 32'hDEAD_BEEF, 5'd8);
        rs_addr = 5'd8;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (wb_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_wb_sel got=%h exp=%h", wb_a, 32'hDEAD_BEEF); end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        checks++;
        if (rs_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_rs8_a got=%h exp=%h", rs_a, 32'hDEAD_BEEF); end
        checks++;
        if (rs_b !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_rs8_b got=%h exp=%h", rs_b, 32'hDEAD_BEEF); end
        checks++;
        if (cnt_a !== 4'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", cnt_a); end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h5555_5555, 5'd9);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #1;
        checks++;
        if (rs_a !== 32'hCAFE_F00D || rt_a !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL bypass_same_cycle got=%h/%h exp=%h", rs_a, rt_a, 32'hCAFE_F00D);
        end
        checks++;
        if (rs_b !== 32'h0 || rt_b !== 32'h0) begin
            failures++; $display("FAIL nobypass_old got=%h/%h exp=%h", rs_b, rt_b, 32'h0);
        end
        rt_addr = 5'd8;
        #1;
        checks++;
        if (rt_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_no_hit got=%h exp=%h", rt_a, 32'hDEAD_BEEF); end
        rt_addr = 5'd9;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        checks++;
        if (rs_b !== 32'hCAFE_F00D || rt_b !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL nobypass_next got=%h/%h exp=%h", rs_b, rt_b, 32'hCAFE_F00D);
        end
        checks++;
        if (cnt_a !== 4'd2) begin failures++; $display("FAIL bypass_cnt got=%0d exp=2", cnt_a); end
    endtask

    task automatic test_reg_zero;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_a !== 32'h0 || rt_a !== 32'h0) begin failures++; $display("FAIL r0_same got=%h/%h exp=0", rs_a, rt_a); end
        checks++;
        if (wb_a !== 32'hFFFF_FFFF) begin failures++; $display("FAIL r0_wb_data got=%h exp=%h", wb_a, 32'hFFFF_FFFF); end
        @(posedge clk);
        #1;
        checks++;
        if (rs_a !== 32'h0 || rs_b !== 32'h0) begin failures++; $display("FAIL r0_next got=%h/%h exp=0", rs_a, rs_b); end
        checks++;
        if (cnt_a !== 4'd2) begin failures++; $display("FAIL r0_cnt got=%0d exp=2", cnt_a); end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_x_dest;
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'bxxxxx;
        alu_result = 32'h1234_ABCD;
        @(posedge clk);
        #1;
        rs_addr = 5'd8;
        rt_addr = 5'd9;
        #1;
        checks++;
        if (rs_a !== 32'hDEAD_BEEF || rt_a !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL xdest_regs got=%h/%h exp=%h/%h", rs_a, rt_a, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        end
        checks++;
        if (cnt_a !== 4'd2) begin failures++; $display("FAIL xdest_cnt got=%0d exp=2", cnt_a); end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_back_to_back;
        // 13 consecutive writes take the counter from 2 to 15
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0, 32'h100 + k, 5'(k));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd3;
        rt_addr = 5'd13;
        #1;
        checks++;
        if (cnt_a !== 4'd15) begin failures++; $display("FAIL b2b_cnt got=%0d exp=15", cnt_a); end
        checks++;
        if (rs_a !== 32'h103 || rt_a !== 32'h10D) begin
            failures++; $display("FAIL b2b_data got=%h/%h exp=%h/%h", rs_a, rt_a, 32'h103, 32'h10D);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_ABCD, 5'd20);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd20;
        #1;
        checks++;
        if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failures++; $display("FAIL wrap_cnt got=%0d/%0d exp=0", cnt_a, cnt_b); end
        checks++;
        if (rs_a !== 32'h0000_ABCD) begin failures++; $display("FAIL wrap_data got=%h exp=%h", rs_a, 32'h0000_ABCD); end
    endtask

    task automatic test_reset_mid;
        logic [4:0] addrs [5];
        addrs = '{5'd3, 5'd8, 5'd12, 5'd13, 5'd20};
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_4444, 5'd12);
        @(posedge clk);
        #1;
        checks++;
        if (cnt_a !== 4'd1) begin failures++; $display("FAIL mid_pre_cnt got=%0d exp=1", cnt_a); end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_7777, 5'd12);
        rs_addr = 5'd12;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 4'd0) begin failures++; $display("FAIL mid_async_cnt got=%0d exp=0", cnt_a); end
        checks++;
        if (rs_a !== 32'h0) begin failures++; $display("FAIL mid_rs_in_reset got=%h exp=0", rs_a); end
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rs_addr = addrs[i];
            rt_addr = addrs[i];
            #1;
            checks++;
            if (rs_a !== 32'h0 || rt_b !== 32'h0) begin
                failures++; $display("FAIL mid_clear r%0d got=%h/%h exp=0", addrs[i], rs_a, rt_b);
            end
        end
        checks++;
        if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failures++; $display("FAIL mid_post_cnt got=%0d/%0d exp=0", cnt_a, cnt_b); end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        test_reset;
        test_alu_write;
        test_bypass;
        test_reg_zero;
        test_x_dest;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
